// File: rtl/rotate_coef_fetch.sv
// rotate_coef_fetch: turns a full-circle angle (quadrant + index) into a signed
// cos/sin pair. It makes two reads from a quarter-wave magnitude ROM that has a
// one-cycle read latency.
// Optional result cache: define ROTATE_COEF_CACHE_EN.
// With the cache, a repeat of the last completed angle skips the ROM reads.
`timescale 1ns/1ps
module rotate_coef_fetch #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  angle_valid,
  output logic                  angle_ready,
  input  logic [ADDR_WIDTH+1:0] angle,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic [DATA_WIDTH:0]   cos_out,
  output logic [DATA_WIDTH:0]   sin_out
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StCap, StOut} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH+1:0] r_angle;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
  logic [DATA_WIDTH-1:0] r_ma;
  logic [DATA_WIDTH:0]   r_cos;
  logic [DATA_WIDTH:0]   r_sin;
  logic [DATA_WIDTH:0]   w_cos;
  logic [DATA_WIDTH:0]   w_sin;
  logic [DATA_WIDTH:0]   w_mag_a;
  logic [DATA_WIDTH:0]   w_mag_b;
  logic [1:0]            w_q;
  logic [ADDR_WIDTH-1:0] w_i;
  logic                  w_accept;
  logic                  w_hit;

  assign w_q         = r_angle[ADDR_WIDTH+1:ADDR_WIDTH];
  assign w_i         = r_angle[ADDR_WIDTH-1:0];
  assign w_accept    = (r_state == StIdle) && angle_valid;
  assign angle_ready = (r_state == StIdle);
  assign coef_valid  = (r_state == StOut);
  assign rom_addr    = r_rom_addr;
  assign cos_out     = r_cos;
  assign sin_out     = r_sin;

`ifdef ROTATE_COEF_CACHE_EN
  logic [ADDR_WIDTH+1:0] r_c_angle;
  logic [DATA_WIDTH:0]   r_c_cos;
  logic [DATA_WIDTH:0]   r_c_sin;
  logic                  r_c_vld;

  assign w_hit = w_accept && r_c_vld && (angle == r_c_angle);

  // Cache register: remembers the last pair handed downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_angle <= '0;
      r_c_cos   <= '0;
      r_c_sin   <= '0;
      r_c_vld   <= 1'b0;
    end else if ((r_state == StOut) && coef_ready) begin
      r_c_angle <= r_angle;
      r_c_cos   <= r_cos;
      r_c_sin   <= r_sin;
      r_c_vld   <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Next state and ROM address; rom_addr only moves when a read is issued
  always_comb begin
    w_state_nxt    = r_state;
    w_rom_addr_nxt = r_rom_addr;
    unique case (r_state)
      StIdle: begin
        if (w_hit) begin
          w_state_nxt = StOut;
        end else if (w_accept) begin
          w_state_nxt    = StRdA;
          w_rom_addr_nxt = angle[ADDR_WIDTH-1:0];
        end
      end
      StRdA: begin
        w_state_nxt    = StRdB;
        w_rom_addr_nxt = -w_i;  // (full - i) mod full
      end
      StRdB:   w_state_nxt = StCap;
      StCap:   w_state_nxt = StOut;
      StOut:   if (coef_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Quadrant mapping of the two magnitudes onto signed cos/sin
  always_comb begin
    w_mag_a = {1'b0, r_ma};
    // m(full) is zero and is never read from the ROM
    w_mag_b = (w_i == '0) ? '0 : {1'b0, rom_rd_data};
    w_cos   = '0;
    w_sin   = '0;
    unique case (w_q)
      2'd0: begin w_cos =  w_mag_a; w_sin =  w_mag_b; end
      2'd1: begin w_cos = -w_mag_b; w_sin =  w_mag_a; end
      2'd2: begin w_cos = -w_mag_a; w_sin = -w_mag_b; end
      default: begin w_cos = w_mag_b; w_sin = -w_mag_a; end
    endcase
  end

  // State, request capture, magnitude capture and output pair registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_angle    <= '0;
      r_rom_addr <= '0;
      r_ma       <= '0;
      r_cos      <= '0;
      r_sin      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      if (w_accept) r_angle <= angle;
      if (r_state == StRdB) r_ma <= rom_rd_data;
      if (r_state == StCap) begin
        r_cos <= w_cos;
        r_sin <= w_sin;
      end
`ifdef ROTATE_COEF_CACHE_EN
      if (w_hit) begin
        r_cos <= r_c_cos;
        r_sin <= r_c_sin;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rotate_coef_fetch.sv
// Bench for rotate_coef_fetch: directed and random angles against an arithmetic
// cos/sin model, with a synchronous ROM holding rom(k) = 1000 + k.
`timescale 1ns/1ps
module tb_rotate_coef_fetch;

`ifdef ROTATE_COEF_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        angle_valid = 1'b0;
  logic        angle_ready;
  logic [9:0]  angle = '0;
  logic [7:0]  rom_addr;
  logic [17:0] rom_rd_data = '0;
  logic        coef_valid;
  logic        coef_ready = 1'b0;
  logic [18:0] cos_out;
  logic [18:0] sin_out;

  int n_cmp = 0;
  int n_err = 0;
  int c_ang = 0;
  bit c_vld = 1'b0;

  rotate_coef_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(18)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .angle_valid(angle_valid),
    .angle_ready(angle_ready),
    .angle      (angle),
    .rom_addr   (rom_addr),
    .rom_rd_data(rom_rd_data),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .cos_out    (cos_out),
    .sin_out    (sin_out)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency
  always @(posedge clk) rom_rd_data <= 18'd1000 + {10'd0, rom_addr};

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mval(input int k);
    return (k == 256) ? 0 : 1000 + k;
  endfunction

  function automatic void model(input int a, output int c, output int s);
    int q;
    int i;
    q = a / 256;
    i = a % 256;
    case (q)
      0:       begin c =  mval(i);       s =  mval(256 - i); end
      1:       begin c = -mval(256 - i); s =  mval(i);       end
      2:       begin c = -mval(i);       s = -mval(256 - i); end
      default: begin c =  mval(256 - i); s = -mval(i);       end
    endcase
  endfunction

  task automatic run_req(input int a, input int hold);
    int lat;
    int ec;
    int es;
    int exp_lat;
    int prev_addr;
    int sc;
    int ss;
    int w;
    w = 0;
    @(negedge clk);
    while (!angle_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_before_req", int'(angle_ready), 1);
    prev_addr = int'(rom_addr);
    exp_lat = (CacheEn && c_vld && c_ang == a) ? 1 : 4;
    angle = a[9:0];
    angle_valid = 1'b1;
    @(posedge clk);
    #1;
    angle_valid = 1'b0;
    angle = 10'($urandom);
    lat = 1;
    if (exp_lat == 4) chk("rom_addr_first", int'(rom_addr), a % 256);
    while (!coef_valid && lat < 20) begin
      @(posedge clk);
      #1;
      angle = 10'($urandom);
      lat++;
      if (exp_lat == 4 && lat == 2) chk("rom_addr_second", int'(rom_addr), (256 - a % 256) % 256);
    end
    chk("latency", lat, exp_lat);
    if (exp_lat == 1) chk("rom_addr_unchanged", int'(rom_addr), prev_addr);
    model(a, ec, es);
    chk("cos", int'($signed(cos_out)), ec);
    chk("sin", int'($signed(sin_out)), es);
    sc = int'($signed(cos_out));
    ss = int'($signed(sin_out));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (k == hold - 1) begin
        chk("hold_valid", int'(coef_valid), 1);
        chk("hold_busy", int'(angle_ready), 0);
        chk("hold_cos", int'($signed(cos_out)), sc);
        chk("hold_sin", int'($signed(sin_out)), ss);
      end
    end
    coef_ready = 1'b1;
    @(posedge clk);
    #1;
    coef_ready = 1'b0;
    chk("release_idle", int'(angle_ready), 1);
    chk("release_valid", int'(coef_valid), 0);
    c_ang = a;
    c_vld = 1'b1;
  endtask

  initial begin
    int a;
    #1;
    chk("rst_ready", int'(angle_ready), 1);
    chk("rst_valid", int'(coef_valid), 0);
    chk("rst_cos", int'(cos_out), 0);
    chk("rst_sin", int'(sin_out), 0);
    chk("rst_addr", int'(rom_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(angle_ready), 1);

    run_req(0, 0);
    run_req(256, 0);
    run_req(300, 10);
    run_req(600, 0);
    run_req(1023, 2);
    run_req(300, 0);
    run_req(300, 1);

    // Reset while the second ROM read is outstanding
    @(negedge clk);
    angle = 10'd600;
    angle_valid = 1'b1;
    @(posedge clk);
    #1;
    angle_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    c_vld = 1'b0;
    chk("abort_valid", int'(coef_valid), 0);
    chk("abort_cos", int'(cos_out), 0);
    chk("abort_sin", int'(sin_out), 0);
    chk("abort_addr", int'(rom_addr), 0);
    chk("abort_ready", int'(angle_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_valid", int'(coef_valid), 0);
    end
    run_req(256, 0);
    run_req(300, 0);
    run_req(300, 0);

    a = 0;
    for (int n = 0; n < 40; n++) begin
      if (($urandom % 4) != 0) a = int'($urandom % 1024);
      run_req(a, int'($urandom % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rotate_coef_fetch.md
ROTATE_COEF_FETCH -- requirements
Module: rotate_coef_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: the rotate ROM address width, giving 256 entries per quarter wave.
REQ-002 Parameter DATA_WIDTH, default 18: the rotate ROM data width, unsigned cos magnitude.
REQ-003 Port clk, input, 1: the single clock. All logic is on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port angle_valid, input, 1: an angle request is present.
REQ-006 Port angle_ready, output, 1: the block can accept a request.
REQ-007 Port angle, input, ADDR_WIDTH+2: full-circle angle, 1024 steps per turn; [9:8] is the quadrant q, [7:0] is the index i.
REQ-008 Port rom_addr, output, ADDR_WIDTH: drives the rotate ROM address.
REQ-009 Port rom_rd_data, input, DATA_WIDTH: rotate ROM data, valid 1 cycle after rom_addr (no output register).
REQ-010 Port coef_valid, output, 1: the coefficient pair is valid.
REQ-011 Port coef_ready, input, 1: downstream accepts the pair.
REQ-012 Port cos_out, output, DATA_WIDTH+1: signed two's-complement cos.
REQ-013 Port sin_out, output, DATA_WIDTH+1: signed two's-complement sin.

Function
REQ-014 The block shall use m(k) = rom(k) for k<256, and m(256) = 0 without a ROM read.
REQ-015 The block shall produce cos = +m(i), -m(256-i), -m(i), +m(256-i) for q = 0, 1, 2, 3 respectively.
REQ-016 The block shall produce sin = +m(256-i), +m(i), -m(256-i), -m(i) for q = 0, 1, 2, 3 respectively.
REQ-017 The FSM shall have the states IDLE, RD_A, RD_B, CAP, OUT.
- IDLE: angle_ready=1; on angle_valid, register q and i and go to RD_A.
- RD_A: rom_addr=i; go to RD_B.
- RD_B: capture m(i); rom_addr=(256-i) mod 256; go to CAP.
- CAP: capture m(256-i), forced to 0 when i==0; go to OUT.
- OUT: coef_valid=1; on coef_ready, go to IDLE.
REQ-018 angle_ready shall be 1 only in IDLE, so at most one request is in flight and angle is ignored in all other states.
REQ-019 coef_valid shall rise on the 4th rising edge after the accepting edge.
REQ-020 While coef_valid=1 and coef_ready=0, cos_out and sin_out shall hold stable.
REQ-021 Negation shall be the two's complement of the zero-extended magnitude, and no overflow is possible at DATA_WIDTH+1 bits.
REQ-022 rom_addr shall hold its last value outside RD_A and RD_B.
REQ-023 There is no simultaneous-request case, because angle_ready=0 in OUT and a new request is taken only after returning to IDLE.

Reset
REQ-024 While rst_n=0, the outputs shall be: state=IDLE, angle_ready=1, coef_valid=0, cos_out=0, sin_out=0, rom_addr=0.
REQ-025 Reset asserted mid-operation shall abort the transaction immediately and discard the pending pair, with no coef_valid afterward.
REQ-026 angle_ready shall be 1 starting with the first cycle after rst_n deasserts.

Configuration
REQ-027 Macro ROTATE_COEF_CACHE_EN controls a result cache.
- Defined: the block keeps the last completed angle and its pair plus a cache-valid flag, which rst_n clears. A request whose angle equals the cached angle, with the flag set, goes IDLE->OUT directly with no ROM access, and coef_valid rises on the 1st edge after accept.
- Undefined: there is no cache logic, and every request follows REQ-017 and REQ-019.

Verification
(Bench ROM model: rom(k) = 1000 + k.)
REQ-028 angle=0 -> cos=+1000, sin=0; coef_valid on the 4th edge after accept; the rom_addr sequence is 0 and no read for the zero term.
REQ-029 angle=256 -> cos=0, sin=+1000. angle=300 -> cos=-1212, sin=+1044.
REQ-030 angle=600 -> cos=-1088, sin=-1168. angle=1023 -> cos=+1001, sin=-1255.
REQ-031 Hold coef_ready=0 for 10 cycles at angle=300 -> coef_valid and the data are stable and angle_ready=0; release -> IDLE on the next edge.
REQ-032 Pull rst_n low during RD_B -> coef_valid=0, cos_out=0, sin_out=0, rom_addr=0, angle_ready=1 asynchronously; after release, angle=256 completes normally.
REQ-033 With ROTATE_COEF_CACHE_EN, send angle=300 twice -> the second request gets its pair after 1 edge with no rom_addr change; after a reset, a repeat of 300 takes 4 edges again.
